data_cache: RTL and testbench
=============================

// Module: data_cache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache for the memory stage of the reduced RISC-V core.
//  Sits between the ALU result/store-data path (CPU side) and the data RAM (memory side); its cpu_rdata feeds the
//  ResultSrc writeback mux in place of raw RAM data. One 32-bit word per line. Raises stall to freeze the core on
//  misses and on every store.
// PARAMETERS
//  ADDRESS_WIDTH  32  byte-address width, CPU and memory side
//  DATA_WIDTH     32  word width; must be 32
//  INDEX_BITS     6   log2(line count); 64 lines; tag = ADDRESS_WIDTH-INDEX_BITS-2 bits
// PORTS
//  clk           in   1    single clock, all state on rising edge
//  rst           in   1    synchronous, active-high reset
//  cpu_req       in   1    valid load/store this cycle
//  cpu_we        in   1    1=store, 0=load
//  cpu_dataType  in   2    00 word, 01 byte (unsigned), 10 half (unsigned), 11 treated as word
//  cpu_addr      in   AW   byte address (ALU result)
//  cpu_wdata     in   DW   store data, right-aligned
//  cpu_rdata     out  DW   load data, extracted and zero-extended; valid when cpu_req&!cpu_we&!stall
//  stall         out  1    1 = access not complete; core holds all cpu_* inputs stable
//  mem_req       out  1    memory request, held until mem_ready
//  mem_we        out  1    memory write
//  mem_dataType  out  2    copy of cpu_dataType for writes; 00 for refills
//  mem_addr      out  AW   cpu_addr for writes; {cpu_addr[AW-1:2],2'b00} for refills
//  mem_wdata     out  DW   copy of cpu_wdata
//  mem_ready     in   1    one-cycle ack; mem_rdata valid same cycle for reads
//  mem_rdata     in   DW   full aligned word
//  hit_count     out  32   saturating count of load hits
//  miss_count    out  32   saturating count of load misses (counted once per miss)
// BEHAVIOUR
//  Reset: all valid bits 0 (one cycle), state IDLE, mem_req=0, counters 0, stall=0, cpu_rdata=0.
//  Address split: index=addr[INDEX_BITS+1:2], tag=addr[AW-1:INDEX_BITS+2], offset=addr[1:0].
//  Half accesses ignore addr[0]; word accesses ignore addr[1:0]. No alignment trap.
//  FSM states IDLE, REFILL, WRITE:
//   IDLE, no cpu_req: stall=0, no memory activity.
//   IDLE, load hit: stall=0, cpu_rdata combinational from line, hit_count++ on the edge. Zero-cycle latency.
//   IDLE, load miss: stall=1 combinationally, miss_count++, next state REFILL.
//   REFILL: mem_req=1, mem_we=0, stall=1. On mem_ready the line is written (data, tag, valid=1) and next state is IDLE.
//    Next cycle the same load hits (counted as a hit). Miss cost = mem latency + 1 cycle.
//   IDLE, store: stall=1, next state WRITE.
//   WRITE: mem_req=1, mem_we=1, stall=1. On mem_ready: if tag hit, merge byte/half/word into the line under
//    offset; if miss, cache unchanged (no allocate). Next state IDLE with stall=0 that cycle (store retires).
//    To avoid re-issue, a one-bit done flag suppresses the held store for one cycle.
//  Store to a line then load same address: load hits with merged data, no memory read.
//  mem_req deasserts the cycle after mem_ready; never two outstanding requests.
//  Reset mid-REFILL/WRITE: abandon immediately; no line update; mem_req=0 next cycle.
//  cpu_req dropping while stalled is a protocol violation (undefined); bench asserts against it.
//  Counters saturate at 32'hFFFF_FFFF.
// STRUCTURE
//  data_cache_pkg: state enum (IDLE/REFILL/WRITE), dataType constants (DT_WORD, DT_BYTE, DT_HALF), byte-lane merge
//   and extract functions.
//  Sub-module cache_data_array: valid vector, tag and data arrays; one read port (combinational), one write port
//   (with byte-enables), synchronous clear on rst.
//  data_cache top: FSM, done flag, hit compare, memory interface, counters.
// TESTING
//  Reset, then load 0x100 with mem latency 3 -> stall high 4 cycles, one mem read at 0x100, then cpu_rdata=mem word,
//   miss_count=1.
//  Repeat load 0x100 -> stall=0, cpu_rdata same word same cycle, no mem_req, hit_count increments.
//  Line 0x100 holds 0x11223344, byte store 0xAA at 0x101 -> mem write addr 0x101 dataType 01;
//   then word load 0x100 hits, returns 0x1122AA44.
//  Store to uncached 0x200, then load 0x200 -> store leaves cache untouched; the load misses and refills.
//  Load 0x100 then 0x500 (same index, different tag) -> second load misses; then 0x100 misses again (eviction).
//  rst pulsed during REFILL -> mem_req low next cycle, all lines invalid, counters 0, next load 0x100 misses.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared types and byte-lane helpers for the direct-mapped write-through data cache.
// DATA_WIDTH is fixed at 32, so the lane helpers work on 32-bit words.
package data_cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2
    } state_e;

    typedef logic [1:0] dtype_t;

    localparam dtype_t DT_WORD = 2'b00;
    localparam dtype_t DT_BYTE = 2'b01;
    localparam dtype_t DT_HALF = 2'b10;

    // Halfword accesses ignore addr[0]; code 11 behaves as a word.
    function automatic logic [3:0] store_be(dtype_t dt, logic [1:0] off);
        case (dt)
            DT_BYTE: return 4'b0001 << off;
            DT_HALF: return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(dtype_t dt, logic [31:0] wdata);
        case (dt)
            DT_BYTE: return {4{wdata[7:0]}};
            DT_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(dtype_t dt, logic [1:0] off, logic [31:0] word);
        logic [1:0]  lane;
        logic [31:0] sh;
        lane = (dt == DT_HALF) ? {off[1], 1'b0} : off;
        sh   = word >> {lane, 3'b000};
        case (dt)
            DT_BYTE: return {24'h0, sh[7:0]};
            DT_HALF: return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side signals of the data cache, bundled in one interface.
// The slave view belongs to the cache; the master view is the core plus memory.
interface data_cache_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     cpu_req;
    logic                     cpu_we;
    logic [1:0]               cpu_dataType;
    logic [ADDRESS_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]    cpu_wdata;
    logic [DATA_WIDTH-1:0]    cpu_rdata;
    logic                     stall;

    logic                     mem_req;
    logic                     mem_we;
    logic [1:0]               mem_dataType;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic                     mem_ready;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_dataType, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        output cpu_rdata, stall, mem_req, mem_we, mem_dataType, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_dataType, cpu_addr, cpu_wdata, mem_ready, mem_rdata,
        input  cpu_rdata, stall, mem_req, mem_we, mem_dataType, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_data_array.sv
// Valid/tag/data storage for the direct-mapped cache: combinational read port,
// byte-enabled write port, valid bits cleared synchronously on rst.
module cache_data_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 24,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_BITS-1:0]   rd_index_i,
    output logic                    rd_valid_o,
    output logic [TAG_BITS-1:0]     rd_tag_o,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    input  logic                    wr_en_i,
    input  logic [INDEX_BITS-1:0]   wr_index_i,
    input  logic [TAG_BITS-1:0]     wr_tag_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data need no reset: an invalid line is never read as a hit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wr_be_i[b]) begin
                    data_q[wr_index_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the core's memory stage.
//   state     | meaning
//   ST_IDLE   | serve load hits in zero cycles; start a refill on a load miss or a write on a store
//   ST_REFILL | word read outstanding; line filled on mem_ready
//   ST_WRITE  | write-through outstanding; hit lines merged on mem_ready, store retires that cycle
module data_cache
    import data_cache_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 6
) (
    input  logic        clk,
    input  logic        rst,
    data_cache_if.slave bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - 2;

    state_e state_q, state_d;
    logic   done_q, done_d;
    logic [31:0] hit_q, miss_q;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            off;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;

    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        stall, mem_req, mem_we, hit_inc, miss_inc;
    logic [31:0] cpu_rdata;

    assign index = bus.cpu_addr[INDEX_BITS+1:2];
    assign tag   = bus.cpu_addr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign off   = bus.cpu_addr[1:0];
    assign hit   = rd_valid && (rd_tag == tag);

    cache_data_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_WIDTH (32)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_index_i (index),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en && !rst),
        .wr_index_i (index),
        .wr_tag_i   (tag),
        .wr_be_i    (wr_be),
        .wr_data_i  (wr_data)
    );

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        cpu_rdata = '0;
        wr_en     = 1'b0;
        wr_be     = 4'b1111;
        wr_data   = bus.mem_rdata;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cpu_we) begin
                        // The store that just retired is still on the bus for one cycle.
                        if (!done_q) begin
                            stall   = 1'b1;
                            state_d = ST_WRITE;
                        end
                    end else if (hit) begin
                        cpu_rdata = load_extract(bus.cpu_dataType, off, rd_data);
                        hit_inc   = 1'b1;
                    end else begin
                        stall    = 1'b1;
                        miss_inc = 1'b1;
                        state_d  = ST_REFILL;
                    end
                end
            end
            ST_REFILL: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    wr_en   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall   = !bus.mem_ready;
                if (bus.mem_ready) begin
                    wr_en   = hit;
                    wr_be   = store_be(bus.cpu_dataType, off);
                    wr_data = store_lanes(bus.cpu_dataType, bus.cpu_wdata);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (hit_inc && (hit_q != 32'hFFFF_FFFF)) hit_q <= hit_q + 32'd1;
            if (miss_inc && (miss_q != 32'hFFFF_FFFF)) miss_q <= miss_q + 32'd1;
        end
    end

    assign bus.cpu_rdata    = cpu_rdata;
    assign bus.stall        = stall;
    assign bus.mem_req      = mem_req;
    assign bus.mem_we       = mem_we;
    assign bus.mem_dataType = (state_q == ST_WRITE) ? bus.cpu_dataType : DT_WORD;
    assign bus.mem_addr     = (state_q == ST_WRITE) ? bus.cpu_addr
                                                    : {bus.cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata    = bus.cpu_wdata;
    assign hit_count        = hit_q;
    assign miss_count       = miss_q;

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed scenarios then random loads/stores, checked against
// a line-level cache model and a word-addressed memory model.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] hit_count, miss_count;
    int          tests = 0;
    int          fails = 0;

    data_cache_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_cache #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .INDEX_BITS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: 64 lines of {valid, tag, word} plus a sparse backing memory.
    bit          mv [64];
    logic [23:0] mt [64];
    logic [31:0] md [64];
    logic [31:0] mem [int unsigned];
    int unsigned exp_hits, exp_misses;

    function automatic logic [31:0] mem_word(input int unsigned waddr);
        if (mem.exists(waddr)) return mem[waddr];
        return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] ref_extract(input logic [1:0] dt, input logic [1:0] off,
                                                input logic [31:0] w);
        int o;
        o = int'(off);
        if (dt == 2'b01) return (w >> (8 * o)) & 32'h0000_00FF;
        if (dt == 2'b10) return (w >> (16 * (o / 2))) & 32'h0000_FFFF;
        return w;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [1:0] dt, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] r;
        int n, first;
        r = old;
        n = (dt == 2'b01) ? 1 : (dt == 2'b10) ? 2 : 4;
        first = (dt == 2'b01) ? int'(off) : (dt == 2'b10) ? (int'(off) / 2) * 2 : 0;
        for (int i = 0; i < n; i++) r[8*(first+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Core holds a stalled request; cpu_req must not drop until stall clears.
    bit prev_hold = 1'b0;
    always @(posedge clk) begin
        if (!rst && prev_hold && bus.cpu_req !== 1'b1) begin
            fails++;
            $error("FAIL protocol: cpu_req dropped while stalled");
        end
        prev_hold <= (bus.stall === 1'b1) && (bus.cpu_req === 1'b1) && !rst;
    end

    // Drives one access and plays memory with fixed latency `lat`.
    task automatic run_access(input bit we, input logic [1:0] dt, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              output int stall_n, output int txn_n, output int req_n,
                              output logic [31:0] rdata, output logic [31:0] t_addr,
                              output logic [1:0] t_dt, output logic t_we, output logic [31:0] t_wdata);
        int  cur;
        bit  got;
        stall_n = 0; txn_n = 0; req_n = 0; cur = 0; got = 0;
        rdata = '0; t_addr = '0; t_dt = '0; t_we = 1'b0; t_wdata = '0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_dataType = dt;
        bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (bus.mem_req === 1'b1) begin
                req_n++;
                cur++;
                if (cur == lat) begin
                    cur = 0;
                    txn_n++;
                    t_addr = bus.mem_addr; t_dt = bus.mem_dataType;
                    t_we = bus.mem_we; t_wdata = bus.mem_wdata;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_we === 1'b1)
                        mem[bus.mem_addr >> 2] = ref_merge(bus.mem_dataType, bus.mem_addr[1:0],
                                                           mem_word(bus.mem_addr >> 2), bus.mem_wdata);
                    else
                        bus.mem_rdata = mem_word(bus.mem_addr >> 2);
                end
            end
            #1;
            if (bus.stall === 1'b0) begin
                got = 1;
                rdata = bus.cpu_rdata;
                break;
            end
            stall_n++;
            @(negedge clk);
            bus.mem_ready = 1'b0;
        end
        if (!got) check($sformatf("timeout@%h", addr), 32'd0, 32'd1);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
    endtask

    task automatic do_and_check(input bit we, input logic [1:0] dt, input logic [31:0] addr,
                                input logic [31:0] wdata, input int lat, output logic [31:0] got);
        int          idx, exp_stall, exp_txn;
        logic [23:0] tg;
        logic [1:0]  off, exp_dt;
        bit          hit_m;
        logic [31:0] exp_rdata, exp_addr;
        int          stall_n, txn_n, req_n;
        logic [31:0] rdata, t_addr, t_wdata;
        logic [1:0]  t_dt;
        logic        t_we;
        string       nm;
        idx = int'(addr[7:2]); tg = addr[31:8]; off = addr[1:0];
        hit_m = mv[idx] && (mt[idx] == tg);
        exp_rdata = '0; exp_addr = addr; exp_dt = dt; exp_txn = 1;
        if (!we) begin
            if (hit_m) begin
                exp_stall = 0; exp_txn = 0;
            end else begin
                exp_stall = lat + 1;
                exp_addr = {addr[31:2], 2'b00}; exp_dt = 2'b00;
                mv[idx] = 1'b1; mt[idx] = tg; md[idx] = mem_word(addr >> 2);
                exp_misses++;
            end
            exp_hits++;
            exp_rdata = ref_extract(dt, off, md[idx]);
        end else begin
            exp_stall = lat;
            if (hit_m) md[idx] = ref_merge(dt, off, md[idx], wdata);
        end
        run_access(we, dt, addr, wdata, lat, stall_n, txn_n, req_n, rdata, t_addr, t_dt, t_we, t_wdata);
        nm = $sformatf("%s dt%0d @%h", we ? "st" : "ld", dt, addr);
        check({nm, " stall_cycles"}, 32'(stall_n), 32'(exp_stall));
        check({nm, " mem_txns"}, 32'(txn_n), 32'(exp_txn));
        check({nm, " mem_req_cycles"}, 32'(req_n), 32'(exp_txn * lat));
        if (exp_txn == 1) begin
            check({nm, " mem_addr"}, t_addr, exp_addr);
            check({nm, " mem_dataType"}, {30'd0, t_dt}, {30'd0, exp_dt});
            check({nm, " mem_we"}, {31'd0, t_we}, {31'd0, we});
            if (we) check({nm, " mem_wdata"}, t_wdata, wdata);
        end
        if (!we) check({nm, " rdata"}, rdata, exp_rdata);
        check({nm, " hit_count"}, hit_count, exp_hits);
        check({nm, " miss_count"}, miss_count, exp_misses);
        got = rdata;
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_dataType = 2'b00;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        exp_hits = 0; exp_misses = 0;
        mem[32'h100 >> 2] = 32'h1122_3344;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall", {31'd0, bus.stall}, 32'd0);
        check("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("reset cpu_rdata", bus.cpu_rdata, 32'd0);
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);

        do_and_check(1'b0, 2'b00, 32'h100, 32'h0, 3, r);
        check("first load word", r, 32'h1122_3344);
        do_and_check(1'b0, 2'b00, 32'h100, 32'h0, 3, r);
        do_and_check(1'b1, 2'b01, 32'h101, 32'h0000_00AA, 2, r);
        do_and_check(1'b0, 2'b00, 32'h100, 32'h0, 3, r);
        check("merged byte load", r, 32'h1122_AA44);
        do_and_check(1'b1, 2'b00, 32'h200, 32'hCAFE_F00D, 2, r);
        do_and_check(1'b0, 2'b00, 32'h200, 32'h0, 2, r);
        check("uncached store then load", r, 32'hCAFE_F00D);
        do_and_check(1'b0, 2'b00, 32'h500, 32'h0, 1, r);
        do_and_check(1'b0, 2'b00, 32'h100, 32'h0, 2, r);
        do_and_check(1'b0, 2'b10, 32'h103, 32'h0, 2, r);
        check("half load upper", r, 32'h0000_1122);
        do_and_check(1'b0, 2'b01, 32'h103, 32'h0, 2, r);
        do_and_check(1'b1, 2'b10, 32'h101, 32'h0000_BEEF, 1, r);
        do_and_check(1'b0, 2'b11, 32'h102, 32'h0, 1, r);
        check("half merge via word load", r, 32'h1122_BEEF);

        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            do_and_check(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
                         int'($urandom_range(1, 4)), r);
        end

        // Reset while a refill is outstanding.
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_dataType = 2'b00; bus.cpu_addr = 32'h5F0;
        @(negedge clk);
        #1;
        check("refill pending mem_req", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1; bus.cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("post-rst stall", {31'd0, bus.stall}, 32'd0);
        check("post-rst hit_count", hit_count, 32'd0);
        check("post-rst miss_count", miss_count, 32'd0);
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        exp_hits = 0; exp_misses = 0;
        do_and_check(1'b0, 2'b00, 32'h100, 32'h0, 2, r);
        do_and_check(1'b0, 2'b00, 32'h5F0, 32'h0, 2, r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
